vending_machine_fsm: RTL and testbench
======================================

# vending_machine_fsm

Coin-accepting vending controller for a single product priced at 15 units. It sits between a coin-detector front end and the dispense and change actuators. Each clock it accepts one coin code, tracks accumulated credit, and pulses a dispense flag plus a change code once credit reaches the price. A cancel code refunds any held credit. The module name is `vending_machine_fsm`.

## Interface
- Parameters: none. Price (15), coin values (5, 10) and change encoding are fixed.
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low. Sampled only on the rising edge of clock; 0 = reset.
- x  input  2  coin event for this cycle: 00 none, 01 coin 5, 10 coin 10, 11 cancel/refund.
- y  output  1  dispense pulse, registered; 1 for exactly one cycle per vend.
- z  output  2  change/refund code, registered, in units of 5: 00 none, 01 = 5, 10 = 10; 11 never driven.

## Operation
- Credit state, 3 states:
  - S0 = credit 0
  - S5 = credit 5
  - S10 = credit 10
- Encode states in 2 bits. The unused encoding recovers to S0 on the next edge, with y=0 and z=00.
- x is sampled every rising edge while reset=1. Each cycle x is nonzero counts as one event. Upstream must present a coin for exactly one cycle; holding 01 for 3 cycles inserts three 5-unit coins.
- Transitions (next state / y / z):
  - S0: 00 -> S0/0/00; 01 -> S5/0/00; 10 -> S10/0/00; 11 -> S0/0/00 (nothing to refund).
  - S5: 00 -> S5/0/00; 01 -> S10/0/00; 10 -> S0/1/00 (exact 15); 11 -> S0/0/01 (refund 5).
  - S10: 00 -> S10/0/00; 01 -> S0/1/00 (exact 15); 10 -> S0/1/01 (20 paid, change 5); 11 -> S0/0/10 (refund 10).
- After a vend, credit always returns to 0. Excess credit is never carried into the next purchase; it is returned as z.
- Combinations that can occur:
  - y=1 with z=00 or 01.
  - y=0 with z=01 or 10 on refund only.
- Outputs are registered. Decode them from the current state and x, then register them together with the next state.

## Timing
- Reset: when reset=0 at a rising edge, the next values are state=S0, y=0, z=00.
  - Reset overrides any x on that edge. A coin presented in the reset cycle is discarded and not refunded.
  - Reset asserted mid-transaction (S5/S10) discards the credit silently, with no refund pulse.
- Before the first reset edge, state and outputs are undefined. The bench must apply reset for at least 1 edge.
- Latency: a coin sampled at edge N updates the state at edge N. The resulting y/z are visible after edge N and stay until edge N+1.
  - They then return to 0/00 unless another vend or refund occurs on edge N+1.
- Back-to-back: a new coin is accepted in the cycle immediately after a vend. There is no dead cycle.
  - Example: S10, 01, 01 gives a vend, then S5.
- No handshake. y and z are fire-and-forget one-cycle pulses. Downstream must capture them on the next edge.
- Throughput: at most one coin per cycle and at most one vend per cycle.

## Test plan
- Reset then idle: hold reset=0 for 2 edges with x=10, then release with x=00 for 3 cycles -> y=0, z=00 throughout, state S0.
- Three 5-coins: x=01 for 3 consecutive cycles -> S5, S10, then y=1/z=00 for one cycle after the third edge, state S0.
- Two 10-coins: x=10, 10 -> after second edge y=1, z=01; next cycle y=0, z=00.
- 5 then 10, and 10 then 5: each -> y=1, z=00 on the second coin; then S0.
- Refund: x=10, 11 -> y=0, z=10. x=01, 11 -> z=01. From S0, 11 -> z=00, no state change.
- Reset mid-transaction: x=10, then reset=0 with x=01 -> no vend, no refund, S0. A following 10, 01 vends normally (y=1, z=00).

Source files
------------

// File: rtl/vending_machine_fsm.sv
// Single-product (15 unit) coin controller: 5/10 coins, cancel refunds held credit.
// One coin event per cycle; the next state and the y/z pulses are registered together.
module vending_machine_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] x,
  output logic       y,
  output logic [1:0] z
);

  localparam logic [1:0] S0  = 2'b00;
  localparam logic [1:0] S5  = 2'b01;
  localparam logic [1:0] S10 = 2'b10;

  localparam logic [1:0] X_NONE   = 2'b00;
  localparam logic [1:0] X_COIN5  = 2'b01;
  localparam logic [1:0] X_COIN10 = 2'b10;
  localparam logic [1:0] X_CANCEL = 2'b11;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       y_nxt;
  logic [1:0] z_nxt;

  always_comb begin
    state_nxt = S0;
    y_nxt     = 1'b0;
    z_nxt     = 2'b00;
    case (state)
      S0: begin
        case (x)
          X_COIN5:  state_nxt = S5;
          X_COIN10: state_nxt = S10;
          default:  state_nxt = S0;
        endcase
      end
      S5: begin
        case (x)
          X_NONE:   state_nxt = S5;
          X_COIN5:  state_nxt = S10;
          X_COIN10: y_nxt = 1'b1;
          X_CANCEL: z_nxt = 2'b01;
          default:  state_nxt = S0;
        endcase
      end
      S10: begin
        case (x)
          X_NONE:   state_nxt = S10;
          X_COIN5:  y_nxt = 1'b1;
          X_COIN10: begin
            y_nxt = 1'b1;
            z_nxt = 2'b01;
          end
          X_CANCEL: z_nxt = 2'b10;
          default:  state_nxt = S0;
        endcase
      end
      // Unused encoding drops back to S0 with quiet outputs.
      default: begin
        state_nxt = S0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= S0;
      y     <= 1'b0;
      z     <= 2'b00;
    end else begin
      state <= state_nxt;
      y     <= y_nxt;
      z     <= z_nxt;
    end
  end

endmodule

// File: tb/tb_vending_machine_fsm.sv
// Scoreboard bench: each driven cycle pushes its expected {y,z}; popped and compared after the edge.
module tb_vending_machine_fsm;

  typedef struct packed {
    logic       rst;
    logic [1:0] xv;
    logic [2:0] yz;
  } step_t;

  logic       clock;
  logic       reset;
  logic [1:0] x;
  logic       y;
  logic [1:0] z;

  logic [2:0] sb[$];
  int         n_chk;
  int         n_fail;

  vending_machine_fsm dut (
    .clock (clock),
    .reset (reset),
    .x     (x),
    .y     (y),
    .z     (z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle at the falling edge, record its expectation, land 1 time unit after the rising edge.
  task automatic drive(input logic rst, input logic [1:0] xv, input logic [2:0] exp_yz);
    @(negedge clock);
    reset = rst;
    x     = xv;
    sb.push_back(exp_yz);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$] = '{'{1'b0, 2'b10, 3'b000}, '{1'b0, 2'b10, 3'b000},
                    '{1'b1, 2'b00, 3'b000}, '{1'b1, 2'b00, 3'b000}, '{1'b1, 2'b00, 3'b000},
                    '{1'b1, 2'b10, 3'b000}, '{1'b1, 2'b01, 3'b100}};
    logic [2:0] exp;
    foreach (s[i]) begin
      drive(s[i].rst, s[i].xv, s[i].yz);
      exp = sb.pop_front();
      n_chk++;
      if ({y, z} !== exp) begin
        n_fail++;
        $display("FAIL reset[%0d]: y,z=%b required %b", i, {y, z}, exp);
      end
    end
  endtask

  task automatic test_three_fives();
    step_t s[$] = '{'{1'b1, 2'b01, 3'b000}, '{1'b1, 2'b01, 3'b000},
                    '{1'b1, 2'b01, 3'b100}, '{1'b1, 2'b00, 3'b000},
                    '{1'b1, 2'b10, 3'b000}, '{1'b1, 2'b01, 3'b100}};
    logic [2:0] exp;
    foreach (s[i]) begin
      drive(s[i].rst, s[i].xv, s[i].yz);
      exp = sb.pop_front();
      n_chk++;
      if ({y, z} !== exp) begin
        n_fail++;
        $display("FAIL three_fives[%0d]: y,z=%b required %b", i, {y, z}, exp);
      end
    end
  endtask

  task automatic test_two_tens();
    step_t s[$] = '{'{1'b1, 2'b00, 3'b000}, '{1'b1, 2'b10, 3'b000},
                    '{1'b1, 2'b10, 3'b101}, '{1'b1, 2'b00, 3'b000}};
    logic [2:0] exp;
    foreach (s[i]) begin
      drive(s[i].rst, s[i].xv, s[i].yz);
      exp = sb.pop_front();
      n_chk++;
      if ({y, z} !== exp) begin
        n_fail++;
        $display("FAIL two_tens[%0d]: y,z=%b required %b", i, {y, z}, exp);
      end
    end
  endtask

  task automatic test_mixed_coins();
    step_t s[$] = '{'{1'b1, 2'b01, 3'b000}, '{1'b1, 2'b10, 3'b100}, '{1'b1, 2'b00, 3'b000},
                    '{1'b1, 2'b10, 3'b000}, '{1'b1, 2'b01, 3'b100}, '{1'b1, 2'b00, 3'b000},
                    '{1'b1, 2'b10, 3'b000}, '{1'b1, 2'b01, 3'b100}};
    logic [2:0] exp;
    foreach (s[i]) begin
      drive(s[i].rst, s[i].xv, s[i].yz);
      exp = sb.pop_front();
      n_chk++;
      if ({y, z} !== exp) begin
        n_fail++;
        $display("FAIL mixed_coins[%0d]: y,z=%b required %b", i, {y, z}, exp);
      end
    end
  endtask

  task automatic test_refund();
    step_t s[$] = '{'{1'b1, 2'b10, 3'b000}, '{1'b1, 2'b11, 3'b010}, '{1'b1, 2'b00, 3'b000},
                    '{1'b1, 2'b01, 3'b000}, '{1'b1, 2'b11, 3'b001}, '{1'b1, 2'b00, 3'b000},
                    '{1'b1, 2'b11, 3'b000}, '{1'b1, 2'b11, 3'b000},
                    '{1'b1, 2'b10, 3'b000}, '{1'b1, 2'b01, 3'b100}};
    logic [2:0] exp;
    foreach (s[i]) begin
      drive(s[i].rst, s[i].xv, s[i].yz);
      exp = sb.pop_front();
      n_chk++;
      if ({y, z} !== exp) begin
        n_fail++;
        $display("FAIL refund[%0d]: y,z=%b required %b", i, {y, z}, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    step_t s[$] = '{'{1'b1, 2'b10, 3'b000}, '{1'b0, 2'b01, 3'b000}, '{1'b1, 2'b00, 3'b000},
                    '{1'b1, 2'b10, 3'b000}, '{1'b1, 2'b01, 3'b100}, '{1'b1, 2'b00, 3'b000},
                    '{1'b1, 2'b01, 3'b000}, '{1'b0, 2'b10, 3'b000},
                    '{1'b1, 2'b10, 3'b000}, '{1'b1, 2'b01, 3'b100}};
    logic [2:0] exp;
    foreach (s[i]) begin
      drive(s[i].rst, s[i].xv, s[i].yz);
      exp = sb.pop_front();
      n_chk++;
      if ({y, z} !== exp) begin
        n_fail++;
        $display("FAIL reset_mid[%0d]: y,z=%b required %b", i, {y, z}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    // S10,01,01 vends then leaves S5; a held 01 vends every third cycle.
    step_t s[$] = '{'{1'b1, 2'b10, 3'b000}, '{1'b1, 2'b01, 3'b100}, '{1'b1, 2'b01, 3'b000},
                    '{1'b1, 2'b10, 3'b100}, '{1'b1, 2'b10, 3'b000}, '{1'b1, 2'b10, 3'b101},
                    '{1'b1, 2'b01, 3'b000}, '{1'b1, 2'b01, 3'b000}, '{1'b1, 2'b01, 3'b100},
                    '{1'b1, 2'b01, 3'b000}, '{1'b1, 2'b01, 3'b000}, '{1'b1, 2'b01, 3'b100},
                    '{1'b1, 2'b00, 3'b000}};
    logic [2:0] exp;
    foreach (s[i]) begin
      drive(s[i].rst, s[i].xv, s[i].yz);
      exp = sb.pop_front();
      n_chk++;
      if ({y, z} !== exp) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: y,z=%b required %b", i, {y, z}, exp);
      end
    end
  endtask

  // Random coins against an arithmetic credit model.
  task automatic test_random();
    int         credit;
    int         sum;
    logic       rst;
    logic [1:0] xv;
    logic [2:0] yz;
    logic [2:0] exp;
    credit = 0;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 29) != 0);
      xv  = 2'($urandom_range(0, 3));
      yz  = 3'b000;
      if (!rst) begin
        credit = 0;
      end else if (xv == 2'b11) begin
        yz     = {1'b0, 2'(credit / 5)};
        credit = 0;
      end else if (xv != 2'b00) begin
        sum = credit + ((xv == 2'b01) ? 5 : 10);
        if (sum >= 15) begin
          yz     = {1'b1, 2'((sum - 15) / 5)};
          credit = 0;
        end else begin
          credit = sum;
        end
      end
      drive(rst, xv, yz);
      exp = sb.pop_front();
      n_chk++;
      if ({y, z} !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] x=%b rst=%b: y,z=%b required %b", i, xv, rst, {y, z}, exp);
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    x      = 2'b00;
    test_reset();
    test_three_fives();
    test_two_tens();
    test_mixed_coins();
    test_refund();
    test_reset_mid();
    test_back_to_back();
    drive(1'b0, 2'b00, 3'b000);
    void'(sb.pop_front());
    test_random();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
